sun_sweep_scheduler: RTL



---
 rtl/sun_sweep_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sun_sweep_scheduler.sv
// Solar tracker sweep scheduler: sweeps the stepper, records the
// brightest position, returns to it and holds with optional rescan.
module sun_sweep_scheduler #(
  parameter int          TICK_CYCLES  = 50000000,
  parameter int          POSITIONS    = 11,
  parameter int          SETTLE_TICKS = 1,
  parameter int          HOLD_TICKS   = 10,
  parameter logic [3:0]  MIN_LEVEL    = 4'd1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_rescan,
  input  logic [3:0] light,
  output logic       step_req,
  output logic       step_dir,
  input  logic       step_ack,
  output logic       motor_on,
  output logic [3:0] position,
  output logic [3:0] peak_level,
  output logic [3:0] peak_pos,
  output logic [2:0] state,
  output logic [3:0] hold_count,
  output logic       done
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_RELOAD = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE    = TW'(1);
  localparam logic [3:0] LAST_POS = 4'(POSITIONS - 1);
  localparam logic [3:0] SETTLE_N = 4'(SETTLE_TICKS);
  localparam logic [3:0] HOLD_N   = 4'(HOLD_TICKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOME   = 3'd1,
    S_SETTLE = 3'd2,
    S_STEP   = 3'd3,
    S_RETURN = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    settle_q, settle_d;
  logic [3:0]    pos_q, pos_d;
  logic [3:0]    plvl_q, plvl_d;
  logic [3:0]    ppos_q, ppos_d;
  logic [3:0]    hold_q, hold_d;
  logic          req_q, req_d;
  logic          dir_q, dir_d;
  logic          tick;

  // Next-state, timing and step handshake logic
  always_comb begin
    state_d  = state_q;
    tick_d   = TICK_RELOAD;
    settle_d = '0;
    pos_d    = pos_q;
    plvl_d   = plvl_q;
    ppos_d   = ppos_q;
    hold_d   = hold_q;
    req_d    = req_q;
    dir_d    = dir_q;
    tick     = 1'b0;

    if (state_q == S_SETTLE || state_q == S_HOLD) begin
      tick   = (tick_q == '0);
      tick_d = tick ? TICK_RELOAD : tick_q - TICK_ONE;
    end
    if (state_q == S_SETTLE) begin
      settle_d = settle_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          plvl_d  = MIN_LEVEL;
          ppos_d  = '0;
          state_d = S_HOME;
        end
      end
      S_HOME: begin
        if (req_q) begin
          if (step_ack) begin
            req_d = 1'b0;
            pos_d = pos_q - 4'd1;
          end
        end else if (pos_q != '0) begin
          req_d = 1'b1;
          dir_d = 1'b0;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tick) begin
          if (settle_q + 4'd1 >= SETTLE_N) begin
            settle_d = '0;
            if (light > plvl_q) begin
              plvl_d = light;
              ppos_d = pos_q;
            end
            state_d = (pos_q == LAST_POS) ? S_RETURN : S_STEP;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
      end
      S_STEP: begin
        if (req_q) begin
          if (step_ack) begin
            req_d   = 1'b0;
            pos_d   = pos_q + 4'd1;
            state_d = S_SETTLE;
          end
        end else if (pos_q != LAST_POS) begin
          req_d = 1'b1;
          dir_d = 1'b1;
        end else begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        if (req_q) begin
          if (step_ack) begin
            req_d = 1'b0;
            pos_d = pos_q - 4'd1;
          end
        end else if (pos_q > ppos_q) begin
          req_d = 1'b1;
          dir_d = 1'b0;
        end else begin
          hold_d  = HOLD_N;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (start) begin
          plvl_d  = MIN_LEVEL;
          ppos_d  = '0;
          state_d = S_HOME;
        end else if (auto_rescan && tick) begin
          if (hold_q <= 4'd1) begin
            hold_d  = '0;
            plvl_d  = MIN_LEVEL;
            ppos_d  = '0;
            state_d = S_HOME;
          end else begin
            hold_d = hold_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tick_q   <= TICK_RELOAD;
      settle_q <= '0;
      pos_q    <= '0;
      plvl_q   <= MIN_LEVEL;
      ppos_q   <= '0;
      hold_q   <= HOLD_N;
      req_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      pos_q    <= pos_d;
      plvl_q   <= plvl_d;
      ppos_q   <= ppos_d;
      hold_q   <= hold_d;
      req_q    <= req_d;
      dir_q    <= dir_d;
    end
  end

  assign step_req   = req_q;
  assign step_dir   = dir_q;
  assign position   = pos_q;
  assign peak_level = plvl_q;
  assign peak_pos   = ppos_q;
  assign hold_count = hold_q;
  assign state      = state_q;
  assign done       = (state_q == S_HOLD);
  assign motor_on   = (state_q == S_HOME)   ||
                      (state_q == S_SETTLE) ||
                      (state_q == S_STEP)   ||
                      (state_q == S_RETURN);

endmodule
